// File: rtl/sao_offset_apply.sv
// sao_offset_apply
//   SAO offset apply stage for one CTB row of reconstructed pixels. Each pixel
//   gets the signalled offset of its band-offset (BO) class or horizontal
//   edge-offset (EO class 0) category added, and the sum is clipped to pixel
//   range. One pixel is held back (register H) so the EO right neighbour is
//   known before the result is produced; the last pixel of a row is flushed
//   on its own cycle.
//
//   Optional feature macro: SAO_APPLY_BO_EN (band offset). When undefined no
//   BO logic is built, cfg_band_pos is unused and cfg_type 1 is passthrough.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   cfg_valid / cfg_ready    configuration load handshake (ready only in START)
//   cfg_type                 0 off, 1 BO, 2 EO horizontal, 3 off
//   cfg_band_pos             BO start band
//   cfg_offset0..3           signed offsets
//   cfg_row_len              pixels per row minus one
//   in_valid/in_ready/in_pix     input pixel stream
//   out_valid/out_ready/out_pix/out_last  output pixel stream, last marks row end
module sao_offset_apply #(
  parameter int bit_depth       = 8,
  parameter int offset_clip_bit = 4,
  parameter int row_len_bit     = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [1:0]                  cfg_type,
  input  logic [4:0]                  cfg_band_pos,
  input  logic signed [offset_clip_bit:0] cfg_offset0,
  input  logic signed [offset_clip_bit:0] cfg_offset1,
  input  logic signed [offset_clip_bit:0] cfg_offset2,
  input  logic signed [offset_clip_bit:0] cfg_offset3,
  input  logic [row_len_bit-1:0]      cfg_row_len,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [bit_depth-1:0]        in_pix,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [bit_depth-1:0]        out_pix,
  output logic                        out_last
);

  typedef enum logic [1:0] {START = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

  localparam int                   sum_w   = bit_depth + 2;
  localparam logic [1:0]           type_bo = 2'd1;
  localparam logic [1:0]           type_eo = 2'd2;
  localparam logic [row_len_bit-1:0] col_zero = row_len_bit'(0);
  localparam logic [row_len_bit-1:0] col_one  = row_len_bit'(1);

  // Zero-extended pixel plus sign-extended offset, clipped to [0, 2^bit_depth-1].
  function automatic logic [bit_depth-1:0] add_clip(input logic [bit_depth-1:0] pix,
                                                    input logic [offset_clip_bit:0] off);
    logic [sum_w-1:0] sum;
    sum = {2'b00, pix} + {{(sum_w-offset_clip_bit-1){off[offset_clip_bit]}}, off};
    if (sum[sum_w-1]) begin
      add_clip = {bit_depth{1'b0}};
    end else if (sum[sum_w-2]) begin
      add_clip = {bit_depth{1'b1}};
    end else begin
      add_clip = sum[bit_depth-1:0];
    end
  endfunction

  // sign(c-l) + sign(c-r) as a 3-bit two's complement value in -2..2.
  function automatic logic [2:0] edge_sum(input logic [bit_depth-1:0] c,
                                          input logic [bit_depth-1:0] l,
                                          input logic [bit_depth-1:0] r);
    logic [2:0] s;
    s = 3'd0;
    if (c > l) s = s + 3'd1;
    else if (c < l) s = s - 3'd1;
    else s = s;
    if (c > r) s = s + 3'd1;
    else if (c < r) s = s - 3'd1;
    else s = s;
    return s;
  endfunction

  state_t                  state_q, state_d;
  logic [row_len_bit-1:0]  col_q, col_d;
  logic [bit_depth-1:0]    h_q, h_d, l_q, l_d;
  logic                    out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [bit_depth-1:0]    out_pix_q, out_pix_d;
  logic [1:0]              type_q, type_d;
  logic [row_len_bit-1:0]  row_len_q, row_len_d;
  logic [offset_clip_bit:0] off0_q, off0_d, off1_q, off1_d, off2_q, off2_d, off3_q, off3_d;

  logic                    free_s, accept_s, cfg_load_s;
  logic [row_len_bit-1:0]  row_len_eff_s;
  logic [2:0]              edge_s;
  logic [bit_depth-1:0]    eo_pix_s, bo_pix_s, res_pix_s;

  assign free_s     = !out_valid_q || out_ready;
  assign in_ready   = free_s && (state_q != FLUSH);
  assign cfg_ready  = (state_q == START);
  assign cfg_load_s = cfg_valid && cfg_ready;
  assign accept_s   = in_valid && in_ready;
  // A load coinciding with the column-0 pixel decides that row's length.
  assign row_len_eff_s = cfg_load_s ? cfg_row_len : row_len_q;

  assign out_valid = out_valid_q;
  assign out_pix   = out_pix_q;
  assign out_last  = out_last_q;

`ifdef SAO_APPLY_BO_EN
  logic [4:0] band_pos_q, band_pos_d;
  logic [4:0] band_k_s;

  // BO: band of H relative to the start band, wrapping modulo 32.
  always_comb begin
    band_k_s = h_q[bit_depth-1 -: 5] - band_pos_q;
    if (band_k_s < 5'd4) begin
      case (band_k_s[1:0])
        2'd0:    bo_pix_s = add_clip(h_q, off0_q);
        2'd1:    bo_pix_s = add_clip(h_q, off1_q);
        2'd2:    bo_pix_s = add_clip(h_q, off2_q);
        2'd3:    bo_pix_s = add_clip(h_q, off3_q);
        default: bo_pix_s = h_q;
      endcase
    end else begin
      bo_pix_s = h_q;
    end
  end
`else
  logic unused_band_pos_s;
  assign unused_band_pos_s = ^cfg_band_pos;
  assign bo_pix_s          = h_q;
`endif

  // EO class 0: category of H from its left (L) and right (incoming) neighbours.
  always_comb begin
    edge_s = edge_sum(h_q, l_q, in_pix);
    case (edge_s)
      3'b110:  eo_pix_s = add_clip(h_q, off0_q);
      3'b111:  eo_pix_s = add_clip(h_q, off1_q);
      3'b001:  eo_pix_s = add_clip(h_q, off2_q);
      3'b010:  eo_pix_s = add_clip(h_q, off3_q);
      default: eo_pix_s = h_q;
    endcase
  end

  // Result for H; EO leaves column 0 (col_q == 1 in RUN) and the flushed last column unchanged.
  always_comb begin
    case (type_q)
      type_eo: begin
        if ((state_q == RUN) && (col_q != col_one)) res_pix_s = eo_pix_s;
        else res_pix_s = h_q;
      end
      type_bo: res_pix_s = bo_pix_s;
      default: res_pix_s = h_q;
    endcase
  end

  // Next-state logic for the row FSM, pixel pipeline, output register and config.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    h_d         = h_q;
    l_d         = l_q;
    out_pix_d   = out_pix_q;
    out_last_d  = out_last_q;
    out_valid_d = free_s ? 1'b0 : out_valid_q;
    case (state_q)
      START: begin
        if (accept_s) begin
          h_d     = in_pix;
          col_d   = col_q + col_one;
          state_d = (row_len_eff_s == col_zero) ? FLUSH : RUN;
        end else begin
          state_d = START;
        end
      end
      RUN: begin
        if (accept_s) begin
          out_valid_d = 1'b1;
          out_pix_d   = res_pix_s;
          out_last_d  = 1'b0;
          l_d         = h_q;
          h_d         = in_pix;
          col_d       = col_q + col_one;
          state_d     = (col_q == row_len_q) ? FLUSH : RUN;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        if (free_s) begin
          out_valid_d = 1'b1;
          out_pix_d   = res_pix_s;
          out_last_d  = 1'b1;
          col_d       = col_zero;
          state_d     = START;
        end else begin
          state_d = FLUSH;
        end
      end
      default: begin
        state_d = START;
        col_d   = col_zero;
      end
    endcase

    if (cfg_load_s) begin
      type_d    = cfg_type;
      row_len_d = cfg_row_len;
      off0_d    = cfg_offset0;
      off1_d    = cfg_offset1;
      off2_d    = cfg_offset2;
      off3_d    = cfg_offset3;
    end else begin
      type_d    = type_q;
      row_len_d = row_len_q;
      off0_d    = off0_q;
      off1_d    = off1_q;
      off2_d    = off2_q;
      off3_d    = off3_q;
    end
`ifdef SAO_APPLY_BO_EN
    if (cfg_load_s) band_pos_d = cfg_band_pos;
    else band_pos_d = band_pos_q;
`endif
  end

  // State and config registers; reset discards H, L and the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= START;
      col_q       <= col_zero;
      h_q         <= {bit_depth{1'b0}};
      l_q         <= {bit_depth{1'b0}};
      out_valid_q <= 1'b0;
      out_pix_q   <= {bit_depth{1'b0}};
      out_last_q  <= 1'b0;
      type_q      <= 2'd0;
      row_len_q   <= col_zero;
      off0_q      <= {(offset_clip_bit+1){1'b0}};
      off1_q      <= {(offset_clip_bit+1){1'b0}};
      off2_q      <= {(offset_clip_bit+1){1'b0}};
      off3_q      <= {(offset_clip_bit+1){1'b0}};
`ifdef SAO_APPLY_BO_EN
      band_pos_q  <= 5'd0;
`endif
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      h_q         <= h_d;
      l_q         <= l_d;
      out_valid_q <= out_valid_d;
      out_pix_q   <= out_pix_d;
      out_last_q  <= out_last_d;
      type_q      <= type_d;
      row_len_q   <= row_len_d;
      off0_q      <= off0_d;
      off1_q      <= off1_d;
      off2_q      <= off2_d;
      off3_q      <= off3_d;
`ifdef SAO_APPLY_BO_EN
      band_pos_q  <= band_pos_d;
`endif
    end
  end

endmodule

// File: tb/tb_sao_offset_apply.sv
`timescale 1ns/1ps
module tb_sao_offset_apply;

  logic              clk, rst;
  logic              cfg_valid, cfg_ready;
  logic [1:0]        cfg_type;
  logic [4:0]        cfg_band_pos;
  logic signed [4:0] cfg_offset0, cfg_offset1, cfg_offset2, cfg_offset3;
  logic [5:0]        cfg_row_len;
  logic              in_valid, in_ready;
  logic [7:0]        in_pix;
  logic              out_valid, out_ready, out_last;
  logic [7:0]        out_pix;

  sao_offset_apply dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_type(cfg_type),
    .cfg_band_pos(cfg_band_pos),
    .cfg_offset0(cfg_offset0), .cfg_offset1(cfg_offset1),
    .cfg_offset2(cfg_offset2), .cfg_offset3(cfg_offset3),
    .cfg_row_len(cfg_row_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
    .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix), .out_last(out_last)
  );

`ifdef SAO_APPLY_BO_EN
  localparam bit bo_en = 1'b1;
`else
  localparam bit bo_en = 1'b0;
`endif

  typedef struct { int pix; bit last; } exp_t;
  exp_t exp_q[$];
  int   row_q[$];
  int   tests = 0;
  int   fails = 0;
  int   rdy_mode = 0;   // 0 always ready, 1 random, 2 stalled

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sgn(input int v);
    return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
  endfunction

  function automatic int clip8(input int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  // Reference: expected output row computed from the whole input row at once.
  task automatic model_row(input int typ, input int bp, input int o0, input int o1,
                           input int o2, input int o3);
    int n, p, r, e, k;
    int offs[4];
    exp_t x;
    offs[0] = o0; offs[1] = o1; offs[2] = o2; offs[3] = o3;
    n = row_q.size();
    for (int i = 0; i < n; i++) begin
      p = row_q[i];
      r = p;
      if (typ == 2 && i > 0 && i < n - 1) begin
        e = sgn(p - row_q[i-1]) + sgn(p - row_q[i+1]);
        case (e)
          -2: r = clip8(p + offs[0]);
          -1: r = clip8(p + offs[1]);
          1:  r = clip8(p + offs[2]);
          2:  r = clip8(p + offs[3]);
          default: r = p;
        endcase
      end
      k = ((p / 8) - bp + 64) % 32;
      if (typ == 1 && bo_en && k < 4) r = clip8(p + offs[k]);
      x.pix  = r;
      x.last = (i == n - 1);
      exp_q.push_back(x);
    end
  endtask

  // Present one pixel until it is accepted (bounded), then drop valids.
  task automatic drive_pix(input int p, input bit rnd);
    int  g;
    bit  done;
    done = 1'b0;
    g = 0;
    while (!done && g < 500) begin
      @(negedge clk);
      in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_pix   = 8'(p);
      #1;
      if (in_valid && in_ready) done = 1'b1;
      g++;
    end
    check("drive_accept", done, 1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    cfg_valid = 1'b0;
  endtask

  task automatic set_cfg(input int typ, input int bp, input int o0, input int o1,
                         input int o2, input int o3, input int rl);
    cfg_type     = 2'(typ);
    cfg_band_pos = 5'(bp);
    cfg_offset0  = 5'(o0);
    cfg_offset1  = 5'(o1);
    cfg_offset2  = 5'(o2);
    cfg_offset3  = 5'(o3);
    cfg_row_len  = 6'(rl);
  endtask

  // One row from row_q; early loads config a cycle ahead, otherwise with pixel 0.
  task automatic run_row(input int typ, input int bp, input int o0, input int o1,
                         input int o2, input int o3, input bit rnd, input bit early);
    int g;
    model_row(typ, bp, o0, o1, o2, o3);
    set_cfg(typ, bp, o0, o1, o2, o3, row_q.size() - 1);
    if (early) begin
      g = 0;
      @(negedge clk);
      while (!cfg_ready && g < 300) begin
        @(negedge clk);
        g++;
      end
      check("cfg_ready_wait", cfg_ready, 1);
      cfg_valid = 1'b1;
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
    end else begin
      cfg_valid = 1'b1;
    end
    foreach (row_q[i]) drive_pix(row_q[i], rnd);
  endtask

  // Sink side: drive out_ready away from the edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard: every visible output must match the front of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst && out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", out_valid, 0);
        end else begin
          check("out_pix", out_pix, exp_q[0].pix);
          check("out_last", out_last, exp_q[0].last);
          if (!out_ready) check("bp_in_ready", in_ready, 0);
          else void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int g, n, typ, mode;
    exp_t x;
    rst = 1'b1;
    cfg_valid = 1'b0;
    in_valid = 1'b0;
    in_pix = 8'd0;
    set_cfg(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pix", out_pix, 0);
    check("rst_out_last", out_last, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;

    // Passthrough with latency probe
    row_q = '{7, 8, 9, 10};
    model_row(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    set_cfg(0, 0, 0, 0, 0, 0, 3);
    cfg_valid = 1'b1; in_valid = 1'b1; in_pix = 8'd7;
    @(negedge clk);
    cfg_valid = 1'b0;
    check("pt_no_out_yet", out_valid, 0);
    in_pix = 8'd8;
    @(negedge clk);
    check("pt_first_valid", out_valid, 1);
    check("pt_first_pix", out_pix, 7);
    in_pix = 8'd9;
    @(negedge clk);
    in_pix = 8'd10;
    @(negedge clk);
    in_valid = 1'b0;

    // EO example
    row_q = '{10, 5, 10, 10};
    run_row(2, 0, 3, 1, -1, -2, 1'b0, 1'b0);
    // BO with band wrap
    row_q = '{250, 5, 100};
    run_row(1, 30, 1, 2, 3, 4, 1'b0, 1'b1);
    // Clipping high and low
    row_q = '{250};
    run_row(1, 31, 15, 0, 0, 0, 1'b0, 1'b0);
    row_q = '{3};
    run_row(1, 0, -16, 0, 0, 0, 1'b0, 1'b0);

    // Backpressure mid-row
    row_q = '{40, 60, 20, 20, 90, 10, 200, 30};
    fork
      run_row(2, 0, 5, 3, -4, -6, 1'b0, 1'b0);
      begin
        repeat (4) @(posedge clk);
        rdy_mode = 2;
        repeat (5) @(posedge clk);
        rdy_mode = 0;
      end
    join

    // Config during RUN is ignored
    row_q = '{10, 5, 10, 10};
    model_row(0, 0, 0, 0, 0, 0);
    set_cfg(0, 0, 0, 0, 0, 0, 3);
    cfg_valid = 1'b1;
    drive_pix(10, 1'b0);
    drive_pix(5, 1'b0);
    @(negedge clk);
    check("run_cfg_ready", cfg_ready, 0);
    set_cfg(2, 0, 3, 1, -1, -2, 0);
    cfg_valid = 1'b1;
    drive_pix(10, 1'b0);
    drive_pix(10, 1'b0);

    // Reset mid-row, then a one-pixel row on reset config
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    row_q = '{20, 30};
    set_cfg(2, 0, 5, 5, 5, 5, 3);
    cfg_valid = 1'b1;
    drive_pix(20, 1'b0);
    drive_pix(30, 1'b0);
    @(negedge clk);
    check("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_cfg_ready", cfg_ready, 1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    x.pix = 77; x.last = 1'b1;
    exp_q.push_back(x);
    in_valid = 1'b1; in_pix = 8'd77;
    @(negedge clk);
    in_valid = 1'b0;
    check("one_pix_wait", out_valid, 0);
    @(negedge clk);
    check("one_pix_valid", out_valid, 1);
    check("one_pix_last", out_last, 1);

    // Randomized rows under random valid/ready
    rdy_mode = 1;
    for (int r = 0; r < 40; r++) begin
      n = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 40) : $urandom_range(1, 8);
      mode = $urandom_range(0, 2);
      row_q.delete();
      for (int i = 0; i < n; i++) begin
        case (mode)
          0:       row_q.push_back($urandom_range(0, 255));
          1:       row_q.push_back(100 + $urandom_range(0, 2));
          default: row_q.push_back(($urandom_range(0, 1) != 0) ? $urandom_range(0, 7)
                                                              : $urandom_range(248, 255));
        endcase
      end
      typ = $urandom_range(0, 3);
      run_row(typ, $urandom_range(0, 31), $urandom_range(0, 31) - 16, $urandom_range(0, 31) - 16,
              $urandom_range(0, 31) - 16, $urandom_range(0, 31) - 16, 1'b1, $urandom_range(0, 1) != 0);
    end

    rdy_mode = 0;
    g = 0;
    while (exp_q.size() != 0 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    check("drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
